// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - shared widths, ALU/MD op encodings and MD FSM states for the EX stage
package execute_stage_pkg;

    localparam int XLEN  = 32;
    localparam int ALU_W = 4;
    localparam int MD_W  = 3;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SRL   = 4'd3,
        ALU_SRA   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_XOR   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [MD_W-1:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    function automatic logic md_is_div(input logic [MD_W-1:0] op);
        return op[MD_W-1];
    endfunction

    function automatic logic md_a_signed(input logic [MD_W-1:0] op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic md_b_signed(input logic [MD_W-1:0] op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/execute_stage_md.sv
// rtl/execute_stage_md.sv - md_iter_unit: iterative RV32M multiply/divide (FAST_MUL_EN: one-cycle multiply)
module md_iter_unit
    import execute_stage_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic            ack,
    input  logic [MD_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    md_state_e        state;
    md_op_e           op_q;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  acc, lo, mcand, result_q;
    logic             neg_main, neg_rem;

    logic             a_neg, b_neg, div_by_zero, div_ovf;
    logic [XLEN-1:0]  a_mag, b_mag;

    assign a_neg       = md_a_signed(op) & a[XLEN-1];
    assign b_neg       = md_b_signed(op) & b[XLEN-1];
    assign a_mag       = a_neg ? -a : a;
    assign b_mag       = b_neg ? -b : b;
    assign div_by_zero = md_is_div(op) && (b == '0);
    assign div_ovf     = (op == MD_DIV || op == MD_REM) && (a == INT_MIN) && (b == '1);

    // acc is the product high half / running remainder, lo the multiplier / quotient
    logic [XLEN:0]     mul_sum, div_sh;
    logic [XLEN-1:0]   div_diff, acc_n, lo_n;
    logic              div_ok;
    logic [2*XLEN-1:0] prod_u, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_res;

    always_comb begin
        mul_sum  = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : '0);
        div_sh   = {acc, lo[XLEN-1]};
        div_ok   = div_sh >= {1'b0, mcand};
        div_diff = div_sh[XLEN-1:0] - mcand;
        if (md_is_div(op_q)) begin
            acc_n = div_ok ? div_diff : div_sh[XLEN-1:0];
            lo_n  = {lo[XLEN-2:0], div_ok};
        end else begin
            acc_n = mul_sum[XLEN:1];
            lo_n  = {mul_sum[0], lo[XLEN-1:1]};
        end

        prod_u = {acc_n, lo_n};
        prod_s = neg_main ? -prod_u : prod_u;
        quo_s  = neg_main ? -lo_n : lo_n;
        rem_s  = neg_rem ? -acc_n : acc_n;
        case (op_q)
            MD_MUL:                       fix_res = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fix_res = quo_s;
            default:                      fix_res = rem_s;
        endcase
    end

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        fast_a    = {{XLEN{a_neg}}, a};
        fast_b    = {{XLEN{b_neg}}, b};
        fast_prod = fast_a * fast_b;
        fast_res  = (op == MD_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst || flush) begin
            state    <= IDLE;
            op_q     <= MD_MUL;
            cnt      <= '0;
            acc      <= '0;
            lo       <= '0;
            mcand    <= '0;
            result_q <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q <= md_op_e'(op);
                    cnt  <= '0;
                    if (div_by_zero) begin
                        result_q <= (op == MD_REM || op == MD_REMU) ? a : '1;
                        state    <= DONE;
                    end else if (div_ovf) begin
                        result_q <= (op == MD_DIV) ? INT_MIN : '0;
                        state    <= DONE;
`ifdef FAST_MUL_EN
                    end else if (!md_is_div(op)) begin
                        result_q <= fast_res;
                        state    <= DONE;
`endif
                    end else begin
                        acc      <= '0;
                        lo       <= a_mag;
                        mcand    <= b_mag;
                        neg_main <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_n;
                    lo  <= lo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN-1)) begin
                        result_q <= fix_res;
                        state    <= DONE;
                    end
                end
                DONE: if (ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state == BUSY);
    assign done   = (state == DONE);
    assign result = result_q;

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage: single-cycle ALU, RV32M via md_iter_unit (FAST_MUL_EN), EX/MEM handshake
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst,
    input  logic             decode_vaild_i,
    input  logic             execute_control_i,
    input  logic             memory_allow_in_i,
    input  logic [ALU_W-1:0] DD_ALU_op_i,
    input  logic             DD_md_vaild_i,
    input  logic [MD_W-1:0]  DD_md_op_i,
    input  logic             DD_sel_reg_i,
    input  logic [XLEN-1:0]  DD_rs1_data_i,
    input  logic [XLEN-1:0]  DD_rs2_data_i,
    input  logic [XLEN-1:0]  DD_imme_i,
    input  logic [31:0]      DD_PC_i,
    input  logic             DD_need_dstE_i,
    input  logic [4:0]       DD_dstE_i,
    output logic             execute_allow_in_o,
    output logic             execute_ready_o,
    output logic [XLEN-1:0]  E_valE_o,
    output logic [31:0]      E_PC_o,
    output logic             E_need_dstE_o,
    output logic [4:0]       E_dstE_o,
    output logic             E_md_busy_o
);

    logic [XLEN-1:0] op_b, alu_res, md_result;
    logic            md_start, md_busy, md_done, fire;

    assign op_b = DD_sel_reg_i ? DD_rs2_data_i : DD_imme_i;

    always_comb begin
        alu_res = '0;
        case (alu_op_e'(DD_ALU_op_i))
            ALU_ADD:   alu_res = DD_rs1_data_i + op_b;
            ALU_SUB:   alu_res = DD_rs1_data_i - op_b;
            ALU_SLL:   alu_res = DD_rs1_data_i << op_b[4:0];
            ALU_SRL:   alu_res = DD_rs1_data_i >> op_b[4:0];
            ALU_SRA:   alu_res = $signed(DD_rs1_data_i) >>> op_b[4:0];
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(DD_rs1_data_i) < $signed(op_b)};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, DD_rs1_data_i < op_b};
            ALU_XOR:   alu_res = DD_rs1_data_i ^ op_b;
            ALU_OR:    alu_res = DD_rs1_data_i | op_b;
            ALU_AND:   alu_res = DD_rs1_data_i & op_b;
            ALU_PASSB: alu_res = op_b;
            default:   alu_res = '0;
        endcase
    end

    assign md_start = decode_vaild_i & DD_md_vaild_i & execute_control_i;

    md_iter_unit u_md (
        .clk_i  (clk_i),
        .rst    (rst),
        .start  (md_start),
        .flush  (~execute_control_i),
        .ack    (fire & DD_md_vaild_i),
        .op     (DD_md_op_i),
        .a      (DD_rs1_data_i),
        .b      (DD_rs2_data_i),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // An MD instruction is only ready once its result register is loaded
    assign execute_ready_o    = ~rst & decode_vaild_i & execute_control_i & (~DD_md_vaild_i | md_done);
    assign fire               = execute_ready_o & memory_allow_in_i;
    assign execute_allow_in_o = rst | ~decode_vaild_i | fire;
    assign E_valE_o           = rst ? '0 : (DD_md_vaild_i ? md_result : alu_res);
    assign E_md_busy_o        = md_busy;

    assign E_PC_o        = DD_PC_i;
    assign E_need_dstE_o = DD_need_dstE_i;
    assign E_dstE_o      = DD_dstE_i;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst = 1'b1;
    logic        decode_vaild_i = 1'b0;
    logic        execute_control_i = 1'b1;
    logic        memory_allow_in_i = 1'b1;
    logic [3:0]  DD_ALU_op_i = '0;
    logic        DD_md_vaild_i = 1'b0;
    logic [2:0]  DD_md_op_i = '0;
    logic        DD_sel_reg_i = 1'b0;
    logic [31:0] DD_rs1_data_i = '0, DD_rs2_data_i = '0, DD_imme_i = '0;
    logic [31:0] DD_PC_i = '0;
    logic        DD_need_dstE_i = 1'b0;
    logic [4:0]  DD_dstE_i = '0;
    logic        execute_allow_in_o, execute_ready_o, E_need_dstE_o, E_md_busy_o;
    logic [31:0] E_valE_o, E_PC_o;
    logic [4:0]  E_dstE_o;

    int total = 0;
    int bad = 0;

`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    execute_stage dut (
        .clk_i              (clk_i),
        .rst                (rst),
        .decode_vaild_i     (decode_vaild_i),
        .execute_control_i  (execute_control_i),
        .memory_allow_in_i  (memory_allow_in_i),
        .DD_ALU_op_i        (DD_ALU_op_i),
        .DD_md_vaild_i      (DD_md_vaild_i),
        .DD_md_op_i         (DD_md_op_i),
        .DD_sel_reg_i       (DD_sel_reg_i),
        .DD_rs1_data_i      (DD_rs1_data_i),
        .DD_rs2_data_i      (DD_rs2_data_i),
        .DD_imme_i          (DD_imme_i),
        .DD_PC_i            (DD_PC_i),
        .DD_need_dstE_i     (DD_need_dstE_i),
        .DD_dstE_i          (DD_dstE_i),
        .execute_allow_in_o (execute_allow_in_o),
        .execute_ready_o    (execute_ready_o),
        .E_valE_o           (E_valE_o),
        .E_PC_o             (E_PC_o),
        .E_need_dstE_o      (E_need_dstE_o),
        .E_dstE_o           (E_dstE_o),
        .E_md_busy_o        (E_md_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic set_instr(input logic md, input logic [3:0] aop, input logic [2:0] mop,
                             input logic sel, input logic [31:0] r1, input logic [31:0] r2,
                             input logic [31:0] im);
        decode_vaild_i = 1'b1;
        DD_md_vaild_i  = md;
        DD_ALU_op_i    = aop;
        DD_md_op_i     = mop;
        DD_sel_reg_i   = sel;
        DD_rs1_data_i  = r1;
        DD_rs2_data_i  = r2;
        DD_imme_i      = im;
        #1;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (execute_ready_o !== 1'b1 && cyc < 200) begin
            @(posedge clk_i); #1;
            cyc++;
        end
    endtask

    task automatic retire();
        @(posedge clk_i); #1;
        decode_vaild_i = 1'b0;
        DD_md_vaild_i  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_instr(1'b0, ALU_ADD, 3'd0, 1'b0, 32'd5, 32'd0, 32'd3);
        @(posedge clk_i); @(posedge clk_i); #1;
        total++;
        if (execute_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", execute_ready_o); end
        total++;
        if (E_valE_o !== 32'h0) begin bad++; $display("FAIL reset_valE got=%h want=00000000", E_valE_o); end
        total++;
        if (execute_allow_in_o !== 1'b1 || E_md_busy_o !== 1'b0) begin
            bad++; $display("FAIL reset_allow_busy got=%b%b want=10", execute_allow_in_o, E_md_busy_o);
        end
        decode_vaild_i = 1'b0;
        @(posedge clk_i); #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_alu();
        logic [3:0]  op[12];
        logic        sel[12];
        logic [31:0] ra[12], rb[12], im[12], ex[12];
        op  = '{ALU_ADD, ALU_SUB, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
                ALU_XOR, ALU_OR, ALU_AND, ALU_PASSB};
        sel = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        ra  = '{32'd5, 32'd10, 32'd0, 32'd1, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0};
        rb  = '{32'd0, 32'd3, 32'd1, 32'd35, 32'd4, 32'd4, 32'd1, 32'd1, 32'hFF00FF00,
                32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        im  = '{32'hFFFFFFF9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                32'h00000FF0, 32'h00012345};
        ex  = '{32'hFFFFFFFE, 32'd7, 32'hFFFFFFFF, 32'd8, 32'h08000000, 32'hF8000000, 32'd1,
                32'd0, 32'h0FF00FF0, 32'hF0F0FFFF, 32'h000000F0, 32'h00012345};
        memory_allow_in_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            DD_PC_i        = 32'h1000 + 32'(i * 4);
            DD_dstE_i      = 5'(i + 1);
            DD_need_dstE_i = i[0];
            set_instr(1'b0, op[i], 3'd0, sel[i], ra[i], rb[i], im[i]);
            total++;
            if (E_valE_o !== ex[i]) begin bad++; $display("FAIL alu_%0d_valE got=%h want=%h", i, E_valE_o, ex[i]); end
            total++;
            if (execute_ready_o !== 1'b1 || execute_allow_in_o !== 1'b1) begin
                bad++; $display("FAIL alu_%0d_ready_allow got=%b%b want=11", i, execute_ready_o, execute_allow_in_o);
            end
            total++;
            if (E_PC_o !== 32'h1000 + 32'(i * 4) || E_dstE_o !== 5'(i + 1) || E_need_dstE_o !== i[0]) begin
                bad++; $display("FAIL alu_%0d_passthru got=%h/%h/%b want=%h/%h/%b", i, E_PC_o, E_dstE_o,
                                E_need_dstE_o, 32'h1000 + 32'(i * 4), 5'(i + 1), i[0]);
            end
            @(posedge clk_i); #1;
        end
        decode_vaild_i = 1'b0;
        #1;
    endtask

    task automatic test_div();
        int cyc;
        set_instr(1'b1, ALU_ADD, MD_DIV, 1'b1, 32'd7, 32'hFFFFFFFE, 32'd0);
        total++;
        if (execute_ready_o !== 1'b0 || E_md_busy_o !== 1'b0 || execute_allow_in_o !== 1'b0) begin
            bad++; $display("FAIL div_cycle0 got=%b%b%b want=000", execute_ready_o, E_md_busy_o, execute_allow_in_o);
        end
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk_i); #1;
            total++;
            if (E_md_busy_o !== 1'b1 || execute_ready_o !== 1'b0) begin
                bad++; $display("FAIL div_busy_c%0d got=%b%b want=10", k, E_md_busy_o, execute_ready_o);
            end
        end
        @(posedge clk_i); #1;
        total++;
        if (execute_ready_o !== 1'b1 || E_md_busy_o !== 1'b0) begin
            bad++; $display("FAIL div_ready_c33 got=%b%b want=10", execute_ready_o, E_md_busy_o);
        end
        total++;
        if (E_valE_o !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_valE got=%h want=fffffffd", E_valE_o); end
        @(posedge clk_i); #1;
        set_instr(1'b1, ALU_ADD, MD_REM, 1'b1, 32'd7, 32'hFFFFFFFE, 32'd0);
        wait_ready(cyc);
        total++;
        if (cyc != 33) begin bad++; $display("FAIL rem_latency got=%0d want=33", cyc); end
        total++;
        if (E_valE_o !== 32'd1) begin bad++; $display("FAIL rem_valE got=%h want=00000001", E_valE_o); end
        retire();
    endtask

    task automatic test_div_special();
        int cyc;
        logic [2:0]  op[4];
        logic [31:0] ra[4], rb[4], ex[4];
        op = '{MD_DIVU, MD_REMU, MD_DIV, MD_REM};
        ra = '{32'd123, 32'd123, 32'h80000000, 32'h80000000};
        rb = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        ex = '{32'hFFFFFFFF, 32'd123, 32'h80000000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            set_instr(1'b1, ALU_ADD, op[i], 1'b1, ra[i], rb[i], 32'd0);
            wait_ready(cyc);
            total++;
            if (cyc != 1) begin bad++; $display("FAIL divspec_%0d_latency got=%0d want=1", i, cyc); end
            total++;
            if (E_valE_o !== ex[i]) begin bad++; $display("FAIL divspec_%0d_valE got=%h want=%h", i, E_valE_o, ex[i]); end
            retire();
        end
    endtask

    task automatic test_mul();
        int cyc;
        logic [2:0]  op[4];
        logic [31:0] ra[4], rb[4], ex[4];
        op = '{MD_MULH, MD_MUL, MD_MULHU, MD_MULHSU};
        ra = '{32'h80000000, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF};
        rb = '{32'h80000000, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF};
        ex = '{32'h40000000, 32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            set_instr(1'b1, ALU_ADD, op[i], 1'b1, ra[i], rb[i], 32'd0);
            wait_ready(cyc);
            total++;
            if (cyc != MUL_LAT) begin bad++; $display("FAIL mul_%0d_latency got=%0d want=%0d", i, cyc, MUL_LAT); end
            total++;
            if (E_valE_o !== ex[i]) begin bad++; $display("FAIL mul_%0d_valE got=%h want=%h", i, E_valE_o, ex[i]); end
            retire();
        end
    endtask

    task automatic test_flush();
        set_instr(1'b1, ALU_ADD, MD_DIV, 1'b1, 32'd100, 32'd7, 32'd0);
        repeat (10) @(posedge clk_i);
        #1;
        execute_control_i = 1'b0;
        #1;
        total++;
        if (execute_ready_o !== 1'b0 || E_md_busy_o !== 1'b1) begin
            bad++; $display("FAIL flush_c10 got=%b%b want=01", execute_ready_o, E_md_busy_o);
        end
        @(posedge clk_i); #1;
        execute_control_i = 1'b1;
        decode_vaild_i    = 1'b0;
        DD_md_vaild_i     = 1'b0;
        #1;
        total++;
        if (E_md_busy_o !== 1'b0 || execute_ready_o !== 1'b0) begin
            bad++; $display("FAIL flush_idle got=%b%b want=00", E_md_busy_o, execute_ready_o);
        end
        @(posedge clk_i); #1;
        set_instr(1'b0, ALU_ADD, 3'd0, 1'b0, 32'd2, 32'd0, 32'd3);
        total++;
        if (execute_ready_o !== 1'b1 || E_valE_o !== 32'd5) begin
            bad++; $display("FAIL flush_add got=%b/%h want=1/00000005", execute_ready_o, E_valE_o);
        end
        retire();
    endtask

    task automatic test_back_pressure();
        int cyc;
        memory_allow_in_i = 1'b0;
        set_instr(1'b1, ALU_ADD, MD_DIVU, 1'b1, 32'd100, 32'd7, 32'd0);
        wait_ready(cyc);
        total++;
        if (cyc != 33) begin bad++; $display("FAIL bp_latency got=%0d want=33", cyc); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (execute_ready_o !== 1'b1 || E_valE_o !== 32'd14 || execute_allow_in_o !== 1'b0) begin
                bad++; $display("FAIL bp_hold_%0d got=%b/%h/%b want=1/0000000e/0", k, execute_ready_o,
                                E_valE_o, execute_allow_in_o);
            end
            @(posedge clk_i); #1;
        end
        memory_allow_in_i = 1'b1;
        #1;
        total++;
        if (execute_allow_in_o !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", execute_allow_in_o); end
        retire();
        total++;
        if (execute_ready_o !== 1'b0 || E_md_busy_o !== 1'b0 || execute_allow_in_o !== 1'b1) begin
            bad++; $display("FAIL bp_after_fire got=%b%b%b want=001", execute_ready_o, E_md_busy_o, execute_allow_in_o);
        end
        set_instr(1'b1, ALU_ADD, MD_DIVU, 1'b1, 32'd9, 32'd0, 32'd0);
        wait_ready(cyc);
        total++;
        if (cyc != 1) begin bad++; $display("FAIL bp_idle_restart got=%0d want=1", cyc); end
        retire();
    endtask

    task automatic test_reset_mid_busy();
        int cyc;
        set_instr(1'b1, ALU_ADD, MD_DIVU, 1'b1, 32'd100, 32'd7, 32'd0);
        repeat (5) @(posedge clk_i);
        #1;
        rst = 1'b1;
        decode_vaild_i = 1'b0;
        DD_md_vaild_i  = 1'b0;
        @(posedge clk_i); #1;
        rst = 1'b0;
        #1;
        total++;
        if (E_md_busy_o !== 1'b0 || execute_ready_o !== 1'b0) begin
            bad++; $display("FAIL rst_mid_busy got=%b%b want=00", E_md_busy_o, execute_ready_o);
        end
        set_instr(1'b1, ALU_ADD, MD_DIVU, 1'b1, 32'd100, 32'd7, 32'd0);
        wait_ready(cyc);
        total++;
        if (cyc != 33 || E_valE_o !== 32'd14) begin
            bad++; $display("FAIL rst_rerun got=%0d/%h want=33/0000000e", cyc, E_valE_o);
        end
        retire();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_div();
        test_div_special();
        test_mul();
        test_flush();
        test_back_pressure();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
